// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM plus ALU decoder for a shared-memory multicycle MIPS
//   datapath. One instruction takes 3-5 states. FETCH, MEMRD and MEMWR stall
//   on the memory ready handshake.
//
// Parameters
//   MEM_HS     1: memory states wait for mem_ready; 0: mem_ready treated as 1
//
// Ports
//   clk, reset           rising-edge clock, async active-high reset
//   op, funct            opcode / function field from the held IR
//   zero                 ALU zero flag (used in BRANCHEX)
//   mem_ready            memory completes the current access this cycle
//   pcen .. memtoreg     datapath enables and mux selects
//   alucontrol           ALU operation
//   state                current FSM state (debug)
//   illegal              one-cycle pulse in DECODE on unsupported op/funct
module multicycle_controller #(
  parameter bit MEM_HS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCHEX = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JEX      = 4'd11,
    JREX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SLL = 3'b011;

  state_t     cur, nxt;
  logic       rdy;
  logic       is_lw_q;   // load vs store, captured in DECODE
  logic       is_bne_q;  // bne vs beq, captured in DECODE
  logic [2:0] rt_alu;
  logic       rt_known;

  // With the handshake disabled every memory access completes in one cycle.
  assign rdy   = MEM_HS ? mem_ready : 1'b1;
  assign state = cur;

  // R-type function decoder. Unknown functs fall back to add; DECODE flags them.
  always_comb begin
    rt_alu   = ALU_ADD;
    rt_known = 1'b1;
    case (funct)
      F_ADD:   rt_alu = ALU_ADD;
      F_SUB:   rt_alu = ALU_SUB;
      F_AND:   rt_alu = ALU_AND;
      F_OR:    rt_alu = ALU_OR;
      F_SLT:   rt_alu = ALU_SLT;
      F_SLL:   rt_alu = ALU_SLL;
      default: rt_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= FETCH;
      is_lw_q  <= 1'b0;
      is_bne_q <= 1'b0;
    end else begin
      cur <= nxt;
      // op is only trusted in DECODE; later states use the captured flavour.
      if (cur == DECODE) begin
        is_lw_q  <= (op == OP_LW);
        is_bne_q <= (op == OP_BNE);
      end
    end
  end

  always_comb begin
    nxt        = cur;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    illegal    = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b01;
    pcsrc      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alucontrol = ALU_ADD;
    case (cur)
      FETCH: begin
        memread = 1'b1;
        pcen    = rdy;
        irwrite = rdy;
        if (rdy) nxt = DECODE;
      end
      DECODE: begin
        // Branch target PC+4+(imm<<2) lands in ALUOut for BRANCHEX.
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW) begin
          nxt = MEMADR;
        end else if (op == OP_RTYPE) begin
          if (funct == F_JR) begin
            nxt = JREX;
          end else begin
            nxt     = RTYPEEX;
            illegal = ~rt_known;
          end
        end else if (op == OP_BEQ || op == OP_BNE) begin
          nxt = BRANCHEX;
        end else if (op == OP_ADDI) begin
          nxt = ADDIEX;
        end else if (op == OP_J) begin
          nxt = JEX;
        end else begin
          illegal = 1'b1;
          nxt     = FETCH;
        end
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = is_lw_q ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (rdy) nxt = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        nxt      = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (rdy) nxt = FETCH;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b00;
        alucontrol = rt_alu;
        nxt        = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        nxt      = FETCH;
      end
      BRANCHEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b00;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = is_bne_q ? ~zero : zero;
        nxt        = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        nxt      = FETCH;
      end
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
        nxt   = FETCH;
      end
      JREX: begin
        pcsrc = 2'b11;
        pcen  = 1'b1;
        nxt   = FETCH;
      end
      default: nxt = FETCH;  // unused codes recover with strobes low
    endcase
    // Strobes must be quiet while reset is held, even though the state is FETCH.
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pcen, irwrite, regwrite, memread, memwrite, iord, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       regdst, memtoreg, illegal;
  logic [2:0] alucontrol;
  logic [3:0] state;

  // second instance with the handshake disabled
  logic       h_reset, h_zero, h_mr;
  logic [5:0] h_op, h_funct;
  logic       h_pcen, h_irwrite, h_regwrite, h_memread, h_memwrite, h_iord, h_alusrca;
  logic [1:0] h_alusrcb, h_pcsrc;
  logic       h_regdst, h_memtoreg, h_illegal;
  logic [2:0] h_aluc;
  logic [3:0] h_state;

  multicycle_controller #(.MEM_HS(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg), .alucontrol(alucontrol),
    .state(state), .illegal(illegal));

  multicycle_controller #(.MEM_HS(1'b0)) u_nohs (
    .clk(clk), .reset(h_reset), .op(h_op), .funct(h_funct), .zero(h_zero), .mem_ready(h_mr),
    .pcen(h_pcen), .irwrite(h_irwrite), .regwrite(h_regwrite), .memread(h_memread),
    .memwrite(h_memwrite), .iord(h_iord), .alusrca(h_alusrca), .alusrcb(h_alusrcb),
    .pcsrc(h_pcsrc), .regdst(h_regdst), .memtoreg(h_memtoreg), .alucontrol(h_aluc),
    .state(h_state), .illegal(h_illegal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen, irwrite, regwrite, memread, memwrite, illegal, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       regdst, memtoreg;
    logic [2:0] aluc;
  } outs_t;

  typedef struct {
    int    st;
    logic  mr;
    outs_t e;  // expected values
    outs_t m;  // which fields are defined in this state
  } step_t;

  outs_t ob;
  assign ob = {pcen, irwrite, regwrite, memread, memwrite, illegal, iord, alusrca,
               alusrcb, pcsrc, regdst, memtoreg, alucontrol};

  step_t plan[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every step constrains all strobes; selects only where the state defines them.
  function automatic step_t mk(input int st);
    step_t s;
    s.st = st;
    s.mr = 1'($urandom_range(0, 1));
    s.e  = '0;
    s.m  = '0;
    s.m.pcen = 1'b1; s.m.irwrite = 1'b1; s.m.regwrite = 1'b1;
    s.m.memread = 1'b1; s.m.memwrite = 1'b1; s.m.illegal = 1'b1;
    return s;
  endfunction

  function automatic step_t alu(input step_t si, input logic a, input logic [1:0] b,
                                input logic [2:0] c);
    step_t s = si;
    s.e.alusrca = a; s.e.alusrcb = b; s.e.aluc = c;
    s.m.alusrca = 1'b1; s.m.alusrcb = 2'b11; s.m.aluc = 3'b111;
    return s;
  endfunction

  function automatic step_t wb(input step_t si, input logic rd, input logic mtr);
    step_t s = si;
    s.e.regwrite = 1'b1; s.e.regdst = rd; s.e.memtoreg = mtr;
    s.m.regdst = 1'b1; s.m.memtoreg = 1'b1;
    return s;
  endfunction

  function automatic step_t pcs(input step_t si, input logic [1:0] p, input logic en);
    step_t s = si;
    s.e.pcsrc = p; s.m.pcsrc = 2'b11; s.e.pcen = en;
    return s;
  endfunction

  // {known, alucontrol} for an R-type funct
  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'h20:   return {1'b1, 3'b010};
      6'h22:   return {1'b1, 3'b110};
      6'h24:   return {1'b1, 3'b000};
      6'h25:   return {1'b1, 3'b001};
      6'h2a:   return {1'b1, 3'b111};
      6'h00:   return {1'b1, 3'b011};
      default: return {1'b0, 3'b010};
    endcase
  endfunction

  function automatic bit supported_op(input logic [5:0] o);
    return o inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  // kind: 0 lw 1 sw 2 R 3 jr 4 beq 5 bne 6 addi 7 j 8 illegal op
  task automatic run_instr(input int kind, input int fs, input int ms, input logic z,
                           input logic [5:0] fn_in, input logic [5:0] op_in);
    step_t      s;
    logic [5:0] o, fn;
    logic [3:0] ra;
    logic       ill;
    plan.delete();
    fn = fn_in;
    case (kind)
      0: o = 6'h23;  1: o = 6'h2b;  2: o = 6'h00;  3: begin o = 6'h00; fn = 6'h08; end
      4: o = 6'h04;  5: o = 6'h05;  6: o = 6'h08;  7: o = 6'h02;
      default: o = op_in;
    endcase
    ra  = ref_alu(fn);
    ill = (kind == 8) || (kind == 2 && !ra[3]);
    for (int i = 0; i <= fs; i++) begin
      s = alu(mk(0), 1'b0, 2'b01, 3'b010);
      s.mr = (i == fs);
      s = pcs(s, 2'b00, s.mr);
      s.e.irwrite = s.mr; s.e.memread = 1'b1; s.m.iord = 1'b1;
      plan.push_back(s);
    end
    s = alu(mk(1), 1'b0, 2'b11, 3'b010);
    s.e.illegal = ill;
    plan.push_back(s);
    case (kind)
      0, 1: begin
        plan.push_back(alu(mk(2), 1'b1, 2'b10, 3'b010));
        for (int i = 0; i <= ms; i++) begin
          s = mk(kind == 0 ? 3 : 5);
          s.mr = (i == ms);
          s.e.iord = 1'b1; s.m.iord = 1'b1;
          if (kind == 0) s.e.memread = 1'b1; else s.e.memwrite = 1'b1;
          plan.push_back(s);
        end
        if (kind == 0) plan.push_back(wb(mk(4), 1'b0, 1'b1));
      end
      2: begin
        plan.push_back(alu(mk(6), 1'b1, 2'b00, ra[2:0]));
        plan.push_back(wb(mk(7), 1'b1, 1'b0));
      end
      3: plan.push_back(pcs(mk(12), 2'b11, 1'b1));
      4, 5: plan.push_back(pcs(alu(mk(8), 1'b1, 2'b00, 3'b110), 2'b01,
                               kind == 4 ? z : ~z));
      6: begin
        plan.push_back(alu(mk(9), 1'b1, 2'b10, 3'b010));
        plan.push_back(wb(mk(10), 1'b0, 1'b0));
      end
      7: plan.push_back(pcs(mk(11), 2'b10, 1'b1));
      default: ;
    endcase
    foreach (plan[i]) begin
      @(negedge clk);
      if (i == 0) begin op = o; funct = fn; zero = z; end
      mem_ready = plan[i].mr;
      #1;
      chk($sformatf("state k%0d c%0d", kind, i), 32'(state), 32'(plan[i].st));
      chk($sformatf("outs k%0d st%0d", kind, plan[i].st), 32'(ob & plan[i].m),
          32'(plan[i].e & plan[i].m));
    end
  endtask

  outs_t smask;

  initial begin
    logic [5:0] rf, ro;
    int         k;
    smask = '0;
    smask.pcen = 1'b1; smask.irwrite = 1'b1; smask.regwrite = 1'b1;
    smask.memread = 1'b1; smask.memwrite = 1'b1; smask.illegal = 1'b1;
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    h_reset = 1'b1; h_op = 6'h2b; h_funct = '0; h_zero = 1'b0; h_mr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset strobes", 32'(ob & smask), 32'd0);
    chk("reset selects", {iord, alusrca, alusrcb, pcsrc, alucontrol}, {1'b0, 1'b0, 2'b01, 2'b00, 3'b010});
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // directed cases
    run_instr(0, 0, 0, 1'b0, 6'h00, 6'h00);   // lw, no stalls
    run_instr(4, 0, 0, 1'b1, 6'h15, 6'h00);   // beq taken
    run_instr(5, 0, 0, 1'b1, 6'h15, 6'h00);   // bne not taken
    run_instr(3, 0, 0, 1'b0, 6'h08, 6'h00);   // jr
    run_instr(2, 0, 0, 1'b0, 6'h2a, 6'h00);   // slt
    run_instr(6, 3, 0, 1'b0, 6'h00, 6'h00);   // fetch stalls 3 cycles
    run_instr(1, 0, 2, 1'b0, 6'h00, 6'h00);   // sw, 2 stall cycles
    run_instr(8, 0, 0, 1'b0, 6'h00, 6'h3f);   // illegal op
    run_instr(2, 0, 0, 1'b0, 6'h3e, 6'h00);   // unknown funct

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 8);
      rf = 6'($urandom);
      if (k == 2) begin
        case ($urandom_range(0, 6))
          0: rf = 6'h20; 1: rf = 6'h22; 2: rf = 6'h24; 3: rf = 6'h25;
          4: rf = 6'h2a; 5: rf = 6'h00;
          default: while (ref_alu(rf)[3] || rf == 6'h08) rf = 6'($urandom);
        endcase
      end
      ro = 6'($urandom);
      while (supported_op(ro)) ro = 6'($urandom);
      run_instr(k, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                1'($urandom_range(0, 1)), rf, ro);
    end

    // reset asserted in MEMRD aborts at once
    @(negedge clk); op = 6'h23; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-abort state", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    chk("abort state", 32'(state), 32'd0);
    chk("abort strobes", 32'(ob & smask), 32'd0);
    @(negedge clk);
    #1;
    chk("abort held strobes", 32'(ob & smask), 32'd0);
    reset = 1'b0;
    run_instr(7, 0, 0, 1'b0, 6'h00, 6'h00);

    // handshake disabled: sw completes with mem_ready held low
    @(negedge clk);
    h_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("nohs state c%0d", i), 32'(h_state), (i == 1) ? 32'd1 : (i == 2) ? 32'd2 :
          (i == 3) ? 32'd5 : 32'd0);
      chk($sformatf("nohs memwrite c%0d", i), 32'(h_memwrite), (i == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
